// File: rtl/act_requant_pack_pkg.sv
// Shared types and int8 requantization helper for the activation requant/pack path.
package act_requant_pack_pkg;

   localparam int unsigned WORD_LANES = 4;
   localparam int unsigned PROD_W     = 48;

   localparam logic signed [7:0] INT8_MAX = 8'sd127;
   localparam logic signed [7:0] INT8_MIN = -8'sd128;

   typedef struct packed {
      logic [8*WORD_LANES-1:0] data;
      logic [2:0]              count;
      logic                    last;
   } word_t;

   // Round-half-up arithmetic shift, add zero point, clamp to int8.
   function automatic logic signed [7:0] requant(input logic signed [PROD_W-1:0] prod,
                                                 input logic        [4:0]        shift,
                                                 input logic signed [7:0]        zp);
      logic signed [PROD_W:0]   p;
      logic signed [PROD_W:0]   half;
      logic signed [PROD_W:0]   r;
      logic signed [PROD_W+1:0] q;
      p    = {prod[PROD_W-1], prod};
      half = (PROD_W+1)'(1) << (shift - 5'd1);
      if (shift == 5'd0) r = p;
      else               r = (p + half) >>> shift;
      q = {r[PROD_W], r} + (PROD_W+2)'(zp);
      if (q > (PROD_W+2)'(INT8_MAX))      return INT8_MAX;
      else if (q < (PROD_W+2)'(INT8_MIN)) return INT8_MIN;
      return q[7:0];
   endfunction

endpackage

// File: rtl/act_requant_pack_sync_fifo.sv
// Parameterised synchronous FIFO; push and pop on one edge are both honoured, even when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = do_push ? wr_q + {{AW{1'b0}}, 1'b1} : wr_q;
      rd_d = do_pop  ? rd_q + {{AW{1'b0}}, 1'b1} : rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/act_requant_pack.sv
// Requantizes a 32-bit activation stream to int8, packs LANES bytes per word and
// buffers words toward a ready/valid consumer; drops on a full FIFO are flagged sticky.
module act_requant_pack
   import act_requant_pack_pkg::*;
#(
   parameter int unsigned LANES      = WORD_LANES,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SCALE_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic signed [31:0]      data_in,
   input  logic [SCALE_W-1:0]      scale,
   input  logic [4:0]              shift,
   input  logic signed [7:0]       zero_point,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*LANES-1:0]      out_data,
   output logic [2:0]              out_count,
   output logic                    out_last,
   output logic                    overflow
);
   localparam int unsigned LW = $clog2(LANES);

   logic                     vld_p1_q, vld_p2_q;
   logic                     flush_pend_q, flush_pend_d;
   logic                     ovf_q, ovf_d;
   logic [2:0]               lane_cnt_q, lane_cnt_d;
   logic signed [PROD_W-1:0] prod_p1_q;
   logic [4:0]               shift_p1_q;
   logic signed [7:0]        zp_p1_q;
   logic signed [7:0]        byte_p2_q;
   logic [LANES-1:0][7:0]    lanes_q;

   word_t push_word, head_word;
   logic  push, pop, fifo_full, fifo_empty, full_word, resolve;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         lane_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         vld_p1_q     <= valid_in;
         vld_p2_q     <= vld_p1_q;
         lane_cnt_q   <= lane_cnt_d;
         flush_pend_q <= flush_pend_d;
         ovf_q        <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      // Stage 1: widen and multiply, capture the per-sample requant settings
      if (valid_in) begin
         prod_p1_q  <= PROD_W'(data_in) * PROD_W'($signed({1'b0, scale}));
         shift_p1_q <= shift;
         zp_p1_q    <= zero_point;
      end
      // Stage 2: round, offset, saturate
      if (vld_p1_q) byte_p2_q <= requant(prod_p1_q, shift_p1_q, zp_p1_q);
      // Stage 3: lane packing
      if (vld_p2_q) lanes_q[lane_cnt_q[LW-1:0]] <= byte_p2_q;
   end

   always_comb begin
      full_word = vld_p2_q && (lane_cnt_q == 3'(LANES-1));
      // A flush waits until nothing is in flight or about to enter.
      resolve   = flush_pend_q && !valid_in && !vld_p1_q && !vld_p2_q;
      push      = full_word || (resolve && (lane_cnt_q != 3'd0));

      push_word       = '0;
      push_word.count = full_word ? 3'(LANES) : lane_cnt_q;
      push_word.last  = !full_word;
      for (int i = 0; i < LANES; i++) begin
         if (full_word && (i == LANES-1))  push_word.data[8*i +: 8] = byte_p2_q;
         else if (3'(i) < lane_cnt_q)      push_word.data[8*i +: 8] = lanes_q[i];
      end

      lane_cnt_d   = push ? 3'd0 : (vld_p2_q ? lane_cnt_q + 3'd1 : lane_cnt_q);
      flush_pend_d = resolve ? 1'b0 : (flush_pend_q | flush);
      ovf_d        = ovf_q | (push & fifo_full & ~pop);
   end

   assign pop = !fifo_empty && out_ready;

   sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push),
      .wdata_i (push_word),
      .pop_i   (pop),
      .rdata_o (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0   : head_word.data;
   assign out_count = fifo_empty ? 3'd0 : head_word.count;
   assign out_last  = !fifo_empty && head_word.last;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_act_requant_pack.sv
// Bench for act_requant_pack: queue-based reference model checked every cycle, plus literal words.
module tb_act_requant_pack;
   localparam int LANES = 4;
   localparam int DEPTH = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               valid_in = 1'b0;
   logic               flush = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [31:0] data_in = '0;
   logic [15:0]        scale = 16'd1;
   logic [4:0]         shift = '0;
   logic signed [7:0]  zero_point = '0;
   logic               out_valid, out_last, overflow;
   logic [31:0]        out_data;
   logic [2:0]         out_count;

   logic [15:0]        cur_sc = 16'd1;
   logic [4:0]         cur_sh = '0;
   logic signed [7:0]  cur_zp = '0;

   always #5 clk = ~clk;

   act_requant_pack #(.LANES(LANES), .FIFO_DEPTH(DEPTH), .SCALE_W(16)) dut (
      .clk(clk), .reset(rst_n), .valid_in(valid_in), .data_in(data_in),
      .scale(scale), .shift(shift), .zero_point(zero_point), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_last(out_last), .overflow(overflow)
   );

   typedef struct {bit [31:0] d; int cnt; bit last;} word_s;
   typedef struct {longint edge_n; word_s w;} sched_s;

   word_s        mq[$];
   sched_s       sq[$];
   byte unsigned part[$];
   bit           movf;
   longint       k = 0;
   longint       last_samp = -100;
   int           vecs = 0;
   int           fails = 0;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic byte unsigned ref_byte(int d, int unsigned sc, int sh, int zp);
      longint p, r, q;
      p = longint'(d) * longint'(sc);
      if (sh == 0) r = p;
      else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
      q = r + longint'(zp);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   function automatic word_s mk(byte unsigned b[$], bit last);
      word_s w;
      w.d = '0;
      for (int i = 0; i < b.size(); i++) w.d[8*i +: 8] = b[i];
      w.cnt  = b.size();
      w.last = last;
      return w;
   endfunction

   always @(negedge rst_n) begin
      mq.delete(); sq.delete(); part.delete();
      movf = 1'b0;
      last_samp = -100;
   end

   // Reference: sample complete -> word visible 2 edges later; flush resolves once drained.
   always @(posedge clk) begin
      sched_s s;
      k++;
      if (rst_n) begin
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (sq.size() > 0 && sq[0].edge_n == k) begin
            if (mq.size() < DEPTH) mq.push_back(sq[0].w);
            else                   movf = 1'b1;
            void'(sq.pop_front());
         end
         if (valid_in) begin
            part.push_back(ref_byte(data_in, scale, shift, zero_point));
            last_samp = k;
            if (part.size() == LANES) begin
               s.edge_n = k + 2; s.w = mk(part, 1'b0);
               sq.push_back(s);
               part.delete();
            end
         end
         if (flush && part.size() > 0) begin
            s.edge_n = (k + 1 > last_samp + 3) ? k + 1 : last_samp + 3;
            s.w = mk(part, 1'b1);
            sq.push_back(s);
            part.delete();
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("out_valid", out_valid, mq.size() > 0);
      chk("overflow", overflow, movf);
      if (mq.size() > 0) begin
         chk("out_data", out_data, mq[0].d);
         chk("out_count", out_count, mq[0].cnt);
         chk("out_last", out_last, mq[0].last);
      end else begin
         chk("idle_data", out_data, 0);
         chk("idle_count", out_count, 0);
         chk("idle_last", out_last, 0);
      end
   end

   task automatic drive(bit v, int d, bit f);
      @(negedge clk);
      valid_in = v; data_in = d; flush = f;
      scale = cur_sc; shift = cur_sh; zero_point = cur_zp;
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 0, 1'b0);
   endtask

   task automatic expect_head(string nm, logic [31:0] d, int c, bit l);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk({nm, "_timeout"}, 0, 1);
      else begin
         chk({nm, "_data"}, out_data, d);
         chk({nm, "_count"}, out_count, c);
         chk({nm, "_last"}, out_last, l);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", out_data, 0);
      chk("rst_count", out_count, 0);
      chk("rst_last", out_last, 0);
      rst_n = 1'b1;

      // Identity pack with latency
      cur_sc = 16'd1; cur_sh = 5'd0; cur_zp = 8'sd0;
      for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0);
      drive(1'b0, 0, 1'b0);
      chk("lat_e0", out_valid, 0);
      drive(1'b0, 0, 1'b0);
      chk("lat_e1", out_valid, 0);
      @(negedge clk);
      chk("lat_e2", out_valid, 1);
      expect_head("pack", 32'h04030201, 4, 1'b0);

      // Rounding
      cur_sc = 16'd3; cur_sh = 5'd2;
      drive(1'b1, 5, 1'b0); drive(1'b1, 6, 1'b0); drive(1'b1, 7, 1'b0); drive(1'b1, 0, 1'b0);
      idle(1);
      expect_head("round", 32'h00050504, 4, 1'b0);

      // Saturation / zero point, settings changing per sample
      cur_sc = 16'd1000; cur_sh = 5'd0; cur_zp = 8'sd0;   drive(1'b1, 6, 1'b0);
      cur_sc = 16'd1;    cur_zp = -8'sd128;               drive(1'b1, 0, 1'b0);
      cur_zp = 8'sd127;                                   drive(1'b1, 6, 1'b0);
      cur_zp = 8'sd0;                                     drive(1'b1, -1000, 1'b0);
      idle(1);
      expect_head("sat", 32'h807F807F, 4, 1'b0);

      // Flush partial, then flush with nothing packed
      drive(1'b1, 9, 1'b0); drive(1'b1, 10, 1'b0); drive(1'b0, 0, 1'b1);
      idle(5);
      expect_head("flush", 32'h00000A09, 2, 1'b1);
      drive(1'b0, 0, 1'b1);
      idle(6);
      chk("flush2_none", out_valid, 0);

      // Backpressure and overflow
      for (int i = 1; i <= 20; i++) drive(1'b1, i, 1'b0);
      idle(4);
      chk("ovf_set", overflow, 1);
      chk("ovf_held", out_valid, 1);
      expect_head("bp_w0", 32'h04030201, 4, 1'b0);
      expect_head("bp_w1", 32'h08070605, 4, 1'b0);
      expect_head("bp_w2", 32'h0C0B0A09, 4, 1'b0);
      expect_head("bp_w3", 32'h100F0E0D, 4, 1'b0);
      chk("bp_drained", out_valid, 0);

      // Async reset with FIFO non-empty and two lanes packed
      for (int i = 1; i <= 6; i++) drive(1'b1, i, 1'b0);
      idle(3);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0);
      idle(1);
      expect_head("post_rst", 32'h04030201, 4, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int  d;
         bit  f;
         cur_sc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 300));
         cur_sh = 5'($urandom_range(0, 31));
         cur_zp = 8'($urandom_range(0, 255));
         d = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
         f = ($urandom_range(0, 40) == 0);
         drive($urandom_range(0, 9) < 7, d, f);
         out_ready = ($urandom_range(0, 2) != 0);
         if (f) idle(4);
      end
      out_ready = 1'b1;
      idle(12);
      chk("final_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
